cam_stream_capture: RTL and testbench
=====================================

Name: cam_stream_capture

Overview:
Parametrised camera capture front end for the soc_system fabric. It takes byte-serial camera data (cam_data/cam_href/cam_vsync), already synchronised and qualified into the system clock domain, and packs bytes into pixels. It checks frame geometry and buffers pixels in a small FIFO that drives a valid/ready stream with start/end-of-frame markers for the frame-buffer writer / VGA path. It generalises the fixed 8-bit capture path with configurable byte width, bytes per pixel, frame size and buffering, and adds overflow and geometry statistics.

Parameters:
DATA_W, 8, camera byte width
BYTES_PER_PIX, 2, bytes packed per pixel (1..4); PIX_W = DATA_W*BYTES_PER_PIX
FRAME_W, 640, active pixels per line
FRAME_H, 480, active lines per frame
FIFO_DEPTH, 16, output FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  capture enable
stat_clr  in  1  one-cycle pulse clearing frame_cnt, drop_cnt, line_err
cam_valid  in  1  byte strobe (camera pclk edge, pre-synchronised)
cam_data  in  DATA_W  camera byte
cam_href  in  1  line active
cam_vsync  in  1  vertical blanking, active-high
out_data  out  PIX_W  pixel; first byte received in MSBs
out_valid  out  1  FIFO head valid
out_ready  in  1  downstream accept
out_sop  out  1  head is first pixel of frame
out_eop  out  1  head is last pixel of frame
frame_cnt  out  16  completed frames, wraps
drop_cnt  out  16  dropped pixels, saturates at 0xFFFF
line_err  out  1  sticky: a line had != FRAME_W pixels or a frame had != FRAME_H lines
busy  out  1  state == CAPTURE

Behaviour:
- Reset: state IDLE. FIFO empty. out_valid=0, out_sop=0, out_eop=0, out_data=0. frame_cnt=0, drop_cnt=0, line_err=0, busy=0. Byte phase, column and row counters = 0.
- Edges are detected against a registered copy of cam_vsync/cam_href. Frame start = vsync 1->0. Line end = href 1->0.
- FSM:
  - IDLE: go to SYNC when enable=1.
  - SYNC: wait for frame start, then go to CAPTURE with row=col=phase=0.
  - CAPTURE: pack bytes. vsync 0->1 ends the frame:
    - if row==FRAME_H: frame_cnt++;
    - else: set line_err;
    - then go to SYNC.
  - Any state with enable=0 goes to IDLE next cycle. A partial pixel is discarded. FIFO contents remain drainable.
- Packing: in CAPTURE, when cam_href=1 and cam_valid=1, shift cam_data into the pixel register and increment phase. When phase reaches BYTES_PER_PIX-1, the pixel is complete and phase returns to 0. Phase is cleared whenever href=0.
- Pixel tagging:
  - sop = (row==0 && col==0).
  - eop = (row==FRAME_H-1 && col==FRAME_W-1).
  - col increments per completed pixel.
  - Pixels with col>=FRAME_W or row>=FRAME_H are not pushed and set line_err.
- Line end in CAPTURE: if col!=FRAME_W, set line_err. Then row++ and col=0.
- Push rule: a complete pixel is written if FIFO not full, or if a pop occurs in the same cycle (out_valid && out_ready).
- Overflow: otherwise the pixel is dropped and drop_cnt increments (saturating). The frame is aborted: state goes to SYNC, no eop is emitted, and frame_cnt does not increment.
- Latency: a pixel completed in cycle N with the FIFO empty gives out_valid=1 in cycle N+1. Outputs come from FIFO registers.
- Stream rule: out_data/out_sop/out_eop are held stable while out_valid=1 and out_ready=0.
- stat_clr priority: same-cycle stat_clr and increment leaves the counter at 0. stat_clr does not affect the FSM or FIFO.
- reset mid-frame: everything returns to reset values next cycle, including flushing the FIFO.

Optional Feature:
Macro: CAM_TESTPAT_EN
- Defined: adds input testpat (1 bit). When testpat=1, each pushed pixel value = col index, zero-extended or truncated to PIX_W, instead of camera bytes. Timing, counters and markers still come from href/vsync/cam_valid.
- Undefined: no testpat port and no related logic. Pixels are always camera data.

Test Plan:
- Frame geometry: DATA_W=8, BYTES_PER_PIX=2, FRAME_W=4, FRAME_H=2, out_ready=1. Send one frame of bytes 0x01..0x10. Required: 8 pixels 0x0102, 0x0304 … 0x0F10; sop on the first, eop on the last; frame_cnt=1, line_err=0.
- Overflow: FIFO_DEPTH=4 with out_ready=0. Send an 8-pixel frame. Required: 4 pixels buffered, drop_cnt=1, no eop, frame_cnt=0. The next complete frame with out_ready=1 gives frame_cnt=1.
- Short line: a line with 3 pixels when FRAME_W=4 sets line_err=1. stat_clr clears line_err, frame_cnt and drop_cnt to 0.
- Mid-frame disable/reset: deassert enable after 3 bytes. Required: IDLE next cycle and the partial pixel discarded. Re-enable, then drive vsync 1->0: capture restarts with sop on the first pixel. Reset asserted mid-frame gives all outputs 0 next cycle.
- Full-FIFO boundary and stall: with the FIFO full and out_ready=1 in the same cycle a pixel completes, required: no drop and drop_cnt unchanged. With out_ready toggling, out_data is held stable while out_valid=1 and out_ready=0.
- Test pattern (CAM_TESTPAT_EN defined): testpat=1 gives pixel values 0,1,2,3 per line regardless of cam_data.

Source files
------------

// File: rtl/cam_stream_capture.sv
// Byte-serial camera capture: packs bytes into pixels, checks frame geometry
// and streams pixels with sop/eop through a FIFO. Optional: CAM_TESTPAT_EN.
module cam_stream_capture #(
  parameter int DATA_W        = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int FRAME_W       = 640,
  parameter int FRAME_H       = 480,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            stat_clr,
  input  logic                            cam_valid,
  input  logic [DATA_W-1:0]               cam_data,
  input  logic                            cam_href,
  input  logic                            cam_vsync,
`ifdef CAM_TESTPAT_EN
  input  logic                            testpat,
`endif
  output logic [DATA_W*BYTES_PER_PIX-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic [15:0]                     frame_cnt,
  output logic [15:0]                     drop_cnt,
  output logic                            line_err,
  output logic                            busy
);

  localparam int PW   = DATA_W * BYTES_PER_PIX;
  localparam int PHW  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
  localparam int CW   = $clog2(FRAME_W + 2);
  localparam int RW   = $clog2(FRAME_H + 2);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_CAP  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic           vsync_q, href_q;
  logic [PHW-1:0] phase_q, phase_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PW-1:0]  pix_q, pix_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic [15:0]    drop_cnt_q, drop_cnt_d;
  logic           line_err_q, line_err_d;

  logic [PW-1:0]   mem_data_q [FIFO_DEPTH];
  logic            mem_sop_q  [FIFO_DEPTH];
  logic            mem_eop_q  [FIFO_DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CNTW-1:0] cnt_q;

  logic          fs, fe, le;
  logic          pop, full, byte_en, pix_done, in_rng;
  logic          push, drop, push_sop, push_eop;
  logic          frame_inc, err_set;
  logic [PW-1:0] pix_shift, push_data;

  assign fs = vsync_q & ~cam_vsync;
  assign fe = ~vsync_q & cam_vsync;
  assign le = href_q & ~cam_href;

  assign pop  = (cnt_q != '0) & out_ready;
  assign full = (cnt_q == CNTW'(FIFO_DEPTH));

  assign byte_en   = enable & (state_q == S_CAP) & ~fe & cam_href & cam_valid;
  assign pix_shift = (pix_q << DATA_W) | PW'(cam_data);
  assign pix_done  = byte_en & (phase_q == PHW'(BYTES_PER_PIX - 1));
  assign in_rng    = (col_q < CW'(FRAME_W)) & (row_q < RW'(FRAME_H));

  // A pixel may enter a full FIFO when the head leaves in the same cycle
  assign push = pix_done & in_rng & (~full | pop);
  assign drop = pix_done & in_rng & full & ~pop;

  assign push_sop = (row_q == '0) & (col_q == '0);
  assign push_eop = (row_q == RW'(FRAME_H - 1)) & (col_q == CW'(FRAME_W - 1));

`ifdef CAM_TESTPAT_EN
  assign push_data = testpat ? PW'(col_q) : pix_shift;
`else
  assign push_data = pix_shift;
`endif

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    col_d     = col_q;
    row_d     = row_q;
    pix_d     = pix_q;
    frame_inc = 1'b0;
    err_set   = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      phase_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_SYNC;
          phase_d = '0;
        end
        S_SYNC: begin
          phase_d = '0;
          if (fs) begin
            state_d = S_CAP;
            row_d   = '0;
            col_d   = '0;
          end
        end
        S_CAP: begin
          if (fe) begin
            if (row_q == RW'(FRAME_H)) frame_inc = 1'b1;
            else                       err_set   = 1'b1;
            state_d = S_SYNC;
            phase_d = '0;
          end else if (!cam_href) begin
            phase_d = '0;
            if (le) begin
              if (col_q != CW'(FRAME_W)) err_set = 1'b1;
              if (row_q != RW'(FRAME_H + 1)) row_d = row_q + 1'b1;
              col_d = '0;
            end
          end else if (cam_valid) begin
            pix_d   = pix_shift;
            phase_d = pix_done ? '0 : phase_q + 1'b1;
            if (pix_done) begin
              if (!in_rng) err_set = 1'b1;
              if (col_q != CW'(FRAME_W + 1)) col_d = col_q + 1'b1;
              if (drop) state_d = S_SYNC;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q + {15'd0, frame_inc};
    drop_cnt_d  = drop_cnt_q;
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    line_err_d  = line_err_q | err_set;
    if (stat_clr) begin
      frame_cnt_d = '0;
      drop_cnt_d  = '0;
      line_err_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      phase_q     <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pix_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
      line_err_q  <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      vsync_q     <= cam_vsync;
      href_q      <= cam_href;
      phase_q     <= phase_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pix_q       <= pix_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      line_err_q  <= line_err_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wptr_q] <= push_data;
      mem_sop_q[wptr_q]  <= push_sop;
      mem_eop_q[wptr_q]  <= push_eop;
    end
  end

  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem_data_q[rptr_q] : '0;
  assign out_sop   = out_valid & mem_sop_q[rptr_q];
  assign out_eop   = out_valid & mem_eop_q[rptr_q];
  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign line_err  = line_err_q;
  assign busy      = (state_q == S_CAP);

endmodule

// File: tb/tb_cam_stream_capture.sv
// Bench for cam_stream_capture: queue-based reference model checked every
// cycle, plus directed frames with literal expectations.
module tb_cam_stream_capture;

  localparam int DW  = 8;
  localparam int BPP = 2;
  localparam int FW  = 4;
  localparam int FH  = 2;
  localparam int FD  = 4;
  localparam int PW  = DW * BPP;

  logic          clk, reset, enable, stat_clr;
  logic          cam_valid, cam_href, cam_vsync;
  logic [DW-1:0] cam_data;
  logic [PW-1:0] out_data;
  logic          out_valid, out_ready, out_sop, out_eop;
  logic [15:0]   frame_cnt, drop_cnt;
  logic          line_err, busy;
`ifdef CAM_TESTPAT_EN
  logic          testpat;
  initial testpat = 1'b0;
`endif

  cam_stream_capture #(
    .DATA_W(DW), .BYTES_PER_PIX(BPP), .FRAME_W(FW),
    .FRAME_H(FH), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .stat_clr(stat_clr),
    .cam_valid(cam_valid), .cam_data(cam_data),
    .cam_href(cam_href), .cam_vsync(cam_vsync),
`ifdef CAM_TESTPAT_EN
    .testpat(testpat),
`endif
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sop(out_sop), .out_eop(out_eop),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt),
    .line_err(line_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] d;
    bit            s;
    bit            e;
  } pix_t;

  pix_t        mq[$];
  pix_t        rec[$];
  logic [7:0]  part[$];
  int          m_mode;
  bit          pv, ph, lerr;
  int          row, col, fcnt, dcnt;
  int          n_cmp, n_bad;
  bit          rnd_ready;
  bit          prev_stall;
  logic [PW+1:0] prev_out;
  logic [7:0]  seq;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit   pop, fs, fe, le, push, inc_f, inc_d, set_e;
    pix_t np;
    if (reset) begin
      mq.delete(); part.delete();
      m_mode = 0; pv = 0; ph = 0; row = 0; col = 0;
      fcnt = 0; dcnt = 0; lerr = 0;
      return;
    end
    pop = (mq.size() > 0) && out_ready;
    fs = pv && !cam_vsync;
    fe = !pv && cam_vsync;
    le = ph && !cam_href;
    push = 0; inc_f = 0; inc_d = 0; set_e = 0;
    np.d = '0; np.s = 0; np.e = 0;
    if (!enable) begin
      m_mode = 0;
      part.delete();
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (fs) begin
        m_mode = 2; row = 0; col = 0; part.delete();
      end
    end else begin
      if (fe) begin
        if (row == FH) inc_f = 1;
        else set_e = 1;
        m_mode = 1;
        part.delete();
      end else if (!cam_href) begin
        part.delete();
        if (le) begin
          if (col != FW) set_e = 1;
          row++;
          col = 0;
        end
      end else if (cam_valid) begin
        part.push_back(cam_data);
        if (part.size() == BPP) begin
          for (int i = 0; i < BPP; i++) np.d = (np.d << DW) | PW'(part[i]);
          part.delete();
          np.s = (row == 0 && col == 0);
          np.e = (row == FH - 1 && col == FW - 1);
          if (col >= FW || row >= FH) begin
            set_e = 1; col++;
          end else if (mq.size() < FD || pop) begin
            push = 1; col++;
          end else begin
            inc_d = 1; m_mode = 1;
          end
        end
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) mq.push_back(np);
    if (stat_clr) begin
      fcnt = 0; dcnt = 0; lerr = 0;
    end else begin
      fcnt = (fcnt + int'(inc_f)) % 65536;
      if (inc_d && dcnt < 65535) dcnt++;
      if (set_e) lerr = 1;
    end
    pv = cam_vsync;
    ph = cam_href;
  endtask

  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
    if (mq.size() > 0) begin
      chk("out_data", {16'd0, out_data}, {16'd0, mq[0].d});
      chk("out_sop", {31'd0, out_sop}, {31'd0, mq[0].s});
      chk("out_eop", {31'd0, out_eop}, {31'd0, mq[0].e});
    end
    chk("frame_cnt", {16'd0, frame_cnt}, fcnt);
    chk("drop_cnt", {16'd0, drop_cnt}, dcnt);
    chk("line_err", {31'd0, line_err}, {31'd0, lerr});
    chk("busy", {31'd0, busy}, {31'd0, m_mode == 2});
    if (prev_stall && out_valid)
      chk("hold", {14'd0, out_data, out_sop, out_eop}, {14'd0, prev_out});
    prev_stall = out_valid && !out_ready;
    prev_out = {out_data, out_sop, out_eop};
    if (out_valid && out_ready) begin
      pix_t p;
      p.d = out_data; p.s = out_sop; p.e = out_eop;
      rec.push_back(p);
    end
    model_step();
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input int gap);
    cam_valid = 1'b1;
    cam_data = seq;
    seq = seq + 8'd1;
    tick();
    cam_valid = 1'b0;
    cam_data = 8'($urandom);
    repeat (gap) tick();
  endtask

  task automatic send_line(input int npix, input int gmax);
    cam_href = 1'b1;
    tick();
    for (int i = 0; i < npix * BPP; i++) send_byte($urandom_range(0, gmax));
    cam_href = 1'b0;
    repeat (2) tick();
  endtask

  task automatic frame_start();
    cam_vsync = 1'b1;
    repeat (2) tick();
    cam_vsync = 1'b0;
    repeat (2) tick();
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (2) tick();
  endtask

  task automatic frame(input int l0, input int l1, input int gmax);
    frame_start();
    send_line(l0, gmax);
    send_line(l1, gmax);
    frame_end();
  endtask

  task automatic clr_pulse();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 0);
    chk({tag, "_data"}, {16'd0, out_data}, 0);
    chk({tag, "_sopeop"}, {30'd0, out_sop, out_eop}, 0);
    chk({tag, "_fcnt"}, {16'd0, frame_cnt}, 0);
    chk({tag, "_dcnt"}, {16'd0, drop_cnt}, 0);
    chk({tag, "_lerr_busy"}, {30'd0, line_err, busy}, 0);
  endtask

  initial begin
    int neop;
    n_cmp = 0; n_bad = 0;
    rnd_ready = 0; prev_stall = 0; prev_out = '0;
    mq.delete(); part.delete(); m_mode = 0; pv = 0; ph = 0;
    row = 0; col = 0; fcnt = 0; dcnt = 0; lerr = 0;
    reset = 1; enable = 0; stat_clr = 0;
    cam_valid = 0; cam_data = 0; cam_href = 0; cam_vsync = 0;
    out_ready = 0; seq = 0;
    repeat (3) tick();
    chk_zero_outs("reset");

    // Nominal frame, bytes 0x01..0x10
    reset = 0; enable = 1; out_ready = 1;
    repeat (2) tick();
    seq = 8'h01;
    rec.delete();
    frame(4, 4, 0);
    repeat (4) tick();
    chk("geo_count", rec.size(), 8);
    for (int i = 0; i < 8 && i < rec.size(); i++) begin
      chk("geo_data", {16'd0, rec[i].d}, ((2 * i + 1) << 8) | (2 * i + 2));
      chk("geo_sop", {31'd0, rec[i].s}, {31'd0, i == 0});
      chk("geo_eop", {31'd0, rec[i].e}, {31'd0, i == 7});
    end
    chk("geo_fcnt", {16'd0, frame_cnt}, 1);
    chk("geo_lerr", {31'd0, line_err}, 0);

    // Overflow with a stalled sink
    clr_pulse();
    chk("clr_fcnt", {16'd0, frame_cnt}, 0);
    out_ready = 0;
    frame(4, 4, 0);
    chk("ovf_drop", {16'd0, drop_cnt}, 1);
    chk("ovf_fcnt", {16'd0, frame_cnt}, 0);
    chk("ovf_valid", {31'd0, out_valid}, 1);
    rec.delete();
    out_ready = 1;
    repeat (8) tick();
    chk("ovf_buffered", rec.size(), 4);
    neop = 0;
    foreach (rec[i]) if (rec[i].e) neop++;
    chk("ovf_no_eop", neop, 0);
    frame(4, 4, 0);
    chk("ovf_next_fcnt", {16'd0, frame_cnt}, 1);

    // Short line
    frame(3, 4, 0);
    chk("short_lerr", {31'd0, line_err}, 1);
    clr_pulse();
    chk("clr_lerr", {31'd0, line_err}, 0);
    chk("clr_fcnt2", {16'd0, frame_cnt}, 0);
    chk("clr_dcnt", {16'd0, drop_cnt}, 0);

    // Disable after 3 bytes, then restart
    frame_start();
    cam_href = 1;
    tick();
    repeat (3) send_byte(0);
    enable = 0;
    tick();
    chk("dis_busy", {31'd0, busy}, 0);
    cam_href = 0;
    tick();
    enable = 1;
    tick();
    rec.delete();
    seq = 8'h40;
    frame(4, 4, 0);
    repeat (2) tick();
    chk("re_count", rec.size(), 8);
    if (rec.size() > 0) begin
      chk("re_sop", {31'd0, rec[0].s}, 1);
      chk("re_data", {16'd0, rec[0].d}, 32'h4041);
    end
    chk("re_fcnt", {16'd0, frame_cnt}, 1);

    // FIFO full while the head leaves in the same cycle
    out_ready = 0;
    frame_start();
    send_line(4, 0);
    chk("full_valid", {31'd0, out_valid}, 1);
    cam_href = 1;
    tick();
    send_byte(0);
    cam_valid = 1; cam_data = seq; seq = seq + 8'd1;
    out_ready = 1;
    tick();
    cam_valid = 0;
    chk("full_nodrop", {16'd0, drop_cnt}, 0);
    repeat (6) send_byte(0);
    cam_href = 0;
    repeat (2) tick();
    frame_end();
    chk("full_fcnt", {16'd0, frame_cnt}, 2);

    // Randomised frames with a toggling sink
    rnd_ready = 1;
    for (int f = 0; f < 30; f++) begin
      seq = 8'($urandom);
      frame($urandom_range(3, 5), $urandom_range(3, 5), 2);
      if ($urandom_range(0, 5) == 0) clr_pulse();
    end
    rnd_ready = 0;
    out_ready = 1;
    repeat (10) tick();

    // Reset in the middle of a frame
    out_ready = 0;
    frame_start();
    cam_href = 1;
    tick();
    repeat (6) send_byte(0);
    reset = 1;
    tick();
    chk_zero_outs("midrst");
    reset = 0;
    cam_href = 0;
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
